imem_boot_loader: RTL and testbench

- Byte-serial program loader that sits directly upstream of the core's fetch-stage instruction memory.
- Receives a length-prefixed little-endian byte stream over a valid/ready handshake and assembles 32-bit instruction words.
- Writes each word sequentially into the instruction ROM.
- Holds the core in reset until the whole image is written, which removes the need to preload ROM words hierarchically before execution.

---
 rtl/imem_boot_loader.sv | 153 +++++++++++++++
 tb/tb_imem_boot_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: byte-serial loader that fills the instruction ROM from a
// length-prefixed little-endian stream and holds the core in reset until the
// whole image has been written.
module imem_boot_loader #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  input  logic              in_reload,
  output logic              out_imem_we,
  output logic [ADDR_W-1:0] out_imem_addr,
  output logic [31:0]       out_imem_wdata,
  output logic              out_core_reset,
  output logic              out_done,
  output logic              out_error
);

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    DATA,
    WRITE,
    DONE,
    ERROR
  } state_t;

  // One extra bit so the index can reach DEPTH when the image fills memory.
  localparam int          IDX_W   = ADDR_W + 1;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  state_t            state;
  state_t            state_next;
  logic [15:0]       count;
  logic [15:0]       hdr_count;
  logic [1:0]        byte_cnt;
  logic [IDX_W-1:0]  word_idx;
  logic [IDX_W-1:0]  idx_inc;
  logic [23:0]       asm_word;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              accept;

  // in_ready comes from the registered state only; forced low while reset is held.
  assign in_ready  = !reset && (state == HDR_LO || state == HDR_HI || state == DATA);
  assign accept    = in_valid && in_ready;
  assign hdr_count = {in_byte, count[7:0]};
  assign idx_inc   = word_idx + {{(IDX_W-1){1'b0}}, 1'b1};

  assign out_imem_we    = (state == WRITE);
  assign out_imem_addr  = addr_q;
  assign out_imem_wdata = wdata_q;
  assign out_done       = (state == DONE);
  assign out_error      = (state == ERROR);
  assign out_core_reset = (state != DONE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HDR_LO;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: header parse, word assembly, write, done/error parking.
  always_comb begin
    state_next = state;
    case (state)
      HDR_LO: begin
        if (accept) state_next = HDR_HI;
      end
      HDR_HI: begin
        if (accept) begin
          if (hdr_count == 16'd0) begin
            state_next = DONE;
          end else if ({16'd0, hdr_count} > DEPTH_U) begin
            state_next = ERROR;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (accept && byte_cnt == 2'd3) state_next = WRITE;
      end
      WRITE: begin
        if ({{(32-IDX_W){1'b0}}, idx_inc} == {16'd0, count}) begin
          state_next = DONE;
        end else begin
          state_next = DATA;
        end
      end
      DONE: begin
        if (in_reload) state_next = HDR_LO;
      end
      ERROR: begin
        state_next = ERROR;
      end
      default: begin
        state_next = HDR_LO;
      end
    endcase
  end

  // Datapath: header capture, byte lanes, and the held write address/data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= 16'd0;
      byte_cnt <= 2'd0;
      word_idx <= '0;
      asm_word <= 24'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
    end else begin
      case (state)
        HDR_LO: begin
          if (accept) count[7:0] <= in_byte;
        end
        HDR_HI: begin
          if (accept) begin
            count[15:8] <= in_byte;
            byte_cnt    <= 2'd0;
            word_idx    <= '0;
          end
        end
        DATA: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: asm_word[7:0]   <= in_byte;
              2'd1: asm_word[15:8]  <= in_byte;
              2'd2: asm_word[23:16] <= in_byte;
              default: begin
                wdata_q <= {in_byte, asm_word};
                addr_q  <= word_idx[ADDR_W-1:0];
              end
            endcase
          end
        end
        WRITE: begin
          word_idx <= idx_inc;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed scenarios for the instruction-memory boot loader.
module tb_imem_boot_loader;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              in_reload;
  logic              out_imem_we;
  logic [ADDR_W-1:0] out_imem_addr;
  logic [31:0]       out_imem_wdata;
  logic              out_core_reset;
  logic              out_done;
  logic              out_error;

  int tests_run    = 0;
  int tests_failed = 0;
  int we_count     = 0;
  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];

  imem_boot_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_byte       (in_byte),
    .in_ready      (in_ready),
    .in_reload     (in_reload),
    .out_imem_we   (out_imem_we),
    .out_imem_addr (out_imem_addr),
    .out_imem_wdata(out_imem_wdata),
    .out_core_reset(out_core_reset),
    .out_done      (out_done),
    .out_error     (out_error)
  );

  always #5 clk = ~clk;

  // Record every write strobe mid-cycle.
  always @(negedge clk) begin
    if (out_imem_we === 1'b1) begin
      we_count = we_count + 1;
      wr_addr.push_back(out_imem_addr);
      wr_data.push_back(out_imem_wdata);
    end
  end

  // Global time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; in_reload = 1'b0; in_byte = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    we_count = 0; wr_addr.delete(); wr_data.delete();
  endtask

  // Presents a byte and returns just after the edge that accepts it.
  task automatic send_byte(input logic [7:0] b);
    int cycles;
    @(negedge clk);
    in_valid = 1'b1; in_byte = b;
    cycles = 0;
    while (in_ready !== 1'b1 && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    if (in_ready !== 1'b1) begin
      tests_run++; tests_failed++;
      $display("[TB] FAIL send_timeout: in_ready=%b, expected 1 within 50 cycles", in_ready);
    end
    @(posedge clk);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0; in_byte = 8'hFF;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; in_byte = 8'h55; in_reload = 1'b0;
    #1;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_ready: got %b expected 0", in_ready); end
    tests_run++; if (out_core_reset !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_core_reset: got %b expected 1", out_core_reset); end
    tests_run++; if (out_done !== 1'b0 || out_error !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_done_err: got %b/%b expected 0/0", out_done, out_error); end
    tests_run++; if (out_imem_we !== 1'b0 || out_imem_addr !== 10'd0 || out_imem_wdata !== 32'd0) begin tests_failed++; $display("[TB] FAIL rst_write_port: got we=%b addr=%h data=%h expected 0/0/0", out_imem_we, out_imem_addr, out_imem_wdata); end
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_release_ready: got %b expected 1", in_ready); end
    we_count = 0; wr_addr.delete(); wr_data.delete();
  endtask

  task automatic test_continuous();
    logic [7:0] s [10] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      send_byte(s[i]);
      if (i == 5) begin
        #1;
        tests_run++; if (out_imem_we !== 1'b1 || out_imem_addr !== 10'd0 || out_imem_wdata !== 32'h00100093) begin tests_failed++; $display("[TB] FAIL cont_write0: got we=%b addr=%h data=%h expected 1/000/00100093", out_imem_we, out_imem_addr, out_imem_wdata); end
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL cont_ready_in_write: got %b expected 0", in_ready); end
      end
    end
    #1;
    tests_run++; if (out_imem_we !== 1'b1 || out_imem_addr !== 10'd1 || out_imem_wdata !== 32'h00200113) begin tests_failed++; $display("[TB] FAIL cont_write1: got we=%b addr=%h data=%h expected 1/001/00200113", out_imem_we, out_imem_addr, out_imem_wdata); end
    tests_run++; if (out_done !== 1'b0 || out_core_reset !== 1'b1) begin tests_failed++; $display("[TB] FAIL cont_early_done: got done=%b core_reset=%b expected 0/1", out_done, out_core_reset); end
    in_valid = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (out_done !== 1'b1 || out_core_reset !== 1'b0) begin tests_failed++; $display("[TB] FAIL cont_done: got done=%b core_reset=%b expected 1/0", out_done, out_core_reset); end
    tests_run++; if (out_imem_we !== 1'b0 || in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL cont_idle_done: got we=%b ready=%b expected 0/0", out_imem_we, in_ready); end
    repeat (2) @(posedge clk);
    tests_run++; if (we_count !== 2) begin tests_failed++; $display("[TB] FAIL cont_we_count: got %0d expected 2", we_count); end
  endtask

  task automatic test_bubbles();
    logic [7:0] s [10] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
    int cycles;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      send_byte(s[i]);
      idle_cycle();
    end
    cycles = 0;
    while (out_done !== 1'b1 && cycles < 10) begin @(negedge clk); cycles++; end
    repeat (3) @(negedge clk);
    tests_run++; if (we_count !== 2) begin tests_failed++; $display("[TB] FAIL bub_we_count: got %0d expected 2", we_count); end
    tests_run++; if (out_done !== 1'b1) begin tests_failed++; $display("[TB] FAIL bub_done: got %b expected 1", out_done); end
    if (wr_data.size() == 2) begin
      tests_run++; if (wr_addr[0] !== 10'd0 || wr_data[0] !== 32'h00100093) begin tests_failed++; $display("[TB] FAIL bub_write0: got %h/%h expected 000/00100093", wr_addr[0], wr_data[0]); end
      tests_run++; if (wr_addr[1] !== 10'd1 || wr_data[1] !== 32'h00200113) begin tests_failed++; $display("[TB] FAIL bub_write1: got %h/%h expected 001/00200113", wr_addr[1], wr_data[1]); end
    end
  endtask

  task automatic test_zero_count();
    apply_reset();
    send_byte(8'h00);
    send_byte(8'h00);
    #1;
    in_valid = 1'b0;
    tests_run++; if (out_done !== 1'b1 || out_core_reset !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_done: got done=%b core_reset=%b expected 1/0", out_done, out_core_reset); end
    tests_run++; if (in_ready !== 1'b0 || out_error !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_ready_err: got ready=%b err=%b expected 0/0", in_ready, out_error); end
    repeat (3) @(negedge clk);
    tests_run++; if (we_count !== 0) begin tests_failed++; $display("[TB] FAIL zero_we_count: got %0d expected 0", we_count); end
  endtask

  task automatic test_overflow();
    apply_reset();
    send_byte(8'h01);
    send_byte(8'h04);
    #1;
    tests_run++; if (out_error !== 1'b1 || in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_error: got err=%b ready=%b expected 1/0", out_error, in_ready); end
    tests_run++; if (out_core_reset !== 1'b1 || out_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_core: got core_reset=%b done=%b expected 1/0", out_core_reset, out_done); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_byte = 8'(i * 37);
      in_reload = (i == 3);
    end
    @(negedge clk);
    in_valid = 1'b0; in_reload = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++; if (out_error !== 1'b1 || in_ready !== 1'b0 || out_core_reset !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_sticky: got err=%b ready=%b core_reset=%b expected 1/0/1", out_error, in_ready, out_core_reset); end
    tests_run++; if (we_count !== 0) begin tests_failed++; $display("[TB] FAIL ovf_we_count: got %0d expected 0", we_count); end
  endtask

  task automatic test_reload();
    logic [7:0] s [6] = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    apply_reset();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    #1;
    in_valid = 1'b0;
    tests_run++; if (out_imem_we !== 1'b1 || out_imem_wdata !== 32'h44332211) begin tests_failed++; $display("[TB] FAIL rld_first: got we=%b data=%h expected 1/44332211", out_imem_we, out_imem_wdata); end
    @(posedge clk); #1;
    tests_run++; if (out_done !== 1'b1) begin tests_failed++; $display("[TB] FAIL rld_done1: got %b expected 1", out_done); end
    @(negedge clk); in_reload = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (out_core_reset !== 1'b1 || out_done !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rld_restart: got core_reset=%b done=%b ready=%b expected 1/0/1", out_core_reset, out_done, in_ready); end
    @(negedge clk); in_reload = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(s[i]);
    #1;
    in_valid = 1'b0;
    tests_run++; if (out_imem_we !== 1'b1 || out_imem_addr !== 10'd0 || out_imem_wdata !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL rld_write: got we=%b addr=%h data=%h expected 1/000/DEADBEEF", out_imem_we, out_imem_addr, out_imem_wdata); end
    @(posedge clk); #1;
    tests_run++; if (out_done !== 1'b1 || out_core_reset !== 1'b0) begin tests_failed++; $display("[TB] FAIL rld_done2: got done=%b core_reset=%b expected 1/0", out_done, out_core_reset); end
    tests_run++; if (we_count !== 2) begin tests_failed++; $display("[TB] FAIL rld_we_count: got %0d expected 2", we_count); end
  endtask

  // Runs straight after test_reload so the write port still holds DEADBEEF.
  task automatic test_mid_reset();
    logic [7:0] s [6] = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    @(negedge clk); in_reload = 1'b1;
    @(negedge clk); in_reload = 1'b0;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB);
    #2;
    reset = 1'b1; in_valid = 1'b0;
    #1;
    tests_run++; if (out_imem_we !== 1'b0 || out_imem_addr !== 10'd0 || out_imem_wdata !== 32'd0) begin tests_failed++; $display("[TB] FAIL mid_write_port: got we=%b addr=%h data=%h expected 0/000/00000000", out_imem_we, out_imem_addr, out_imem_wdata); end
    tests_run++; if (out_core_reset !== 1'b1 || out_done !== 1'b0 || out_error !== 1'b0 || in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_status: got core_reset=%b done=%b err=%b ready=%b expected 1/0/0/0", out_core_reset, out_done, out_error, in_ready); end
    @(negedge clk);
    reset = 1'b0;
    we_count = 0; wr_addr.delete(); wr_data.delete();
    for (int i = 0; i < 6; i++) send_byte(s[i]);
    #1;
    in_valid = 1'b0;
    tests_run++; if (out_imem_we !== 1'b1 || out_imem_addr !== 10'd0 || out_imem_wdata !== 32'h00000013) begin tests_failed++; $display("[TB] FAIL mid_write: got we=%b addr=%h data=%h expected 1/000/00000013", out_imem_we, out_imem_addr, out_imem_wdata); end
    @(posedge clk); #1;
    tests_run++; if (out_done !== 1'b1 || we_count !== 1) begin tests_failed++; $display("[TB] FAIL mid_done: got done=%b writes=%0d expected 1/1", out_done, we_count); end
  endtask

  task automatic test_full_depth();
    int bad;
    apply_reset();
    send_byte(8'h00);
    send_byte(8'h04);
    #1;
    tests_run++; if (out_error !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_hdr: got err=%b ready=%b expected 0/1", out_error, in_ready); end
    for (int i = 0; i < DEPTH; i++) begin
      send_byte(8'(i)); send_byte(8'(i >> 8)); send_byte(8'h00); send_byte(8'hA5);
    end
    #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (out_done !== 1'b1 || out_error !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_done: got done=%b err=%b expected 1/0", out_done, out_error); end
    repeat (2) @(negedge clk);
    tests_run++; if (we_count !== DEPTH) begin tests_failed++; $display("[TB] FAIL full_we_count: got %0d expected %0d", we_count, DEPTH); end
    bad = 0;
    for (int k = 0; k < wr_data.size(); k++) begin
      if (wr_addr[k] !== 10'(k) || wr_data[k] !== (32'hA5000000 | 32'(k))) bad++;
    end
    tests_run++; if (bad !== 0) begin tests_failed++; $display("[TB] FAIL full_sequence: got %0d bad writes expected 0", bad); end
    if (wr_data.size() == DEPTH) begin
      tests_run++; if (wr_addr[DEPTH-1] !== 10'h3FF || wr_data[DEPTH-1] !== 32'hA50003FF) begin tests_failed++; $display("[TB] FAIL full_last: got %h/%h expected 3FF/A50003FF", wr_addr[DEPTH-1], wr_data[DEPTH-1]); end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_byte = 8'h00; in_reload = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_continuous();
    test_bubbles();
    test_zero_count();
    test_overflow();
    test_reload();
    test_mid_reset();
    test_full_depth();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
